move_history_sequencer: RTL

MOVE_HISTORY_SEQUENCER -- requirements
Module: move_history_sequencer

---
 rtl/chess_pkg.sv | 60 ++++++
 rtl/move_lifo_mem.sv | 38 +++
 rtl/move_history_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// -----------------------------------------------------------------------------
// chess_pkg
// Shared chess encodings for the move-history slice:
//   - piece one-hot codes, castling and en-passant codes
//   - 32-bit move-record layout (typedef + field offsets)
//   - sequencer FSM state type and a square-to-mask helper
// No ports (package).
// -----------------------------------------------------------------------------
package chess_pkg;

    localparam logic [5:0] PIECE_NONE   = 6'b000000;
    localparam logic [5:0] PIECE_PAWN   = 6'b000001;
    localparam logic [5:0] PIECE_ROOK   = 6'b000010;
    localparam logic [5:0] PIECE_KNIGHT = 6'b000100;
    localparam logic [5:0] PIECE_BISHOP = 6'b001000;
    localparam logic [5:0] PIECE_QUEEN  = 6'b010000;
    localparam logic [5:0] PIECE_KING   = 6'b100000;

    localparam logic [1:0] CASTLE_NONE  = 2'b00;
    localparam logic [1:0] CASTLE_QUEEN = 2'b01;
    localparam logic [1:0] CASTLE_KING  = 2'b10;

    localparam logic [4:0] EP_NONE = 5'b00001;
    localparam logic [4:0] EP_UL   = 5'b00010;
    localparam logic [4:0] EP_UR   = 5'b00100;
    localparam logic [4:0] EP_DL   = 5'b01000;
    localparam logic [4:0] EP_DR   = 5'b10000;

    // Record layout, LSB first: from, to, moving, captured, castling, enpassant, color
    localparam int unsigned REC_W          = 32;
    localparam int unsigned REC_FROM_LSB   = 0;
    localparam int unsigned REC_TO_LSB     = 6;
    localparam int unsigned REC_MOVING_LSB = 12;
    localparam int unsigned REC_CAPT_LSB   = 18;
    localparam int unsigned REC_CASTLE_LSB = 24;
    localparam int unsigned REC_EP_LSB     = 26;
    localparam int unsigned REC_COLOR_LSB  = 31;

    typedef struct packed {
        logic       color;
        logic [4:0] enpassant;
        logic [1:0] castling;
        logic [5:0] captured;
        logic [5:0] moving;
        logic [5:0] to_sq;
        logic [5:0] from_sq;
    } move_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        POP,
        RETRACT
    } seq_state_t;

    function automatic logic [63:0] sq_mask(input logic [5:0] sq);
        return 64'd1 << sq;
    endfunction

endpackage

// File: rtl/move_lifo_mem.sv
// -----------------------------------------------------------------------------
// move_lifo_mem
// DEPTH x 32 move-record RAM: synchronous write, registered read.
// Contents are not reset.
// Ports:
//   clk        in   clock
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write address
//   i_wr_data  in   record to write
//   i_rd_addr  in   read address (sampled every rising edge)
//   o_rd_data  out  registered read data
// -----------------------------------------------------------------------------
module move_lifo_mem
    import chess_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [REC_W-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [REC_W-1:0]         o_rd_data
);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/move_history_sequencer.sv
// -----------------------------------------------------------------------------
// move_history_sequencer
// Keeps a LIFO of move records and issues one-cycle command strobes toward the
// board updater: a forward strobe for every accepted push, an undo strobe for
// every retracted move.
// Optional feature: define MOVE_HIST_OVERWRITE_EN to let a push into a full
// history overwrite the oldest record instead of stalling.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   push_valid/push_ready           move-record handshake
//   push_from/to                    square indices 0..63
//   push_moving/captured            piece one-hot (captured 0 = none)
//   push_castling, push_enpassant   move flags
//   push_color                      1 white, 0 black
//   undo_req                        retract most recent move
//   upd_*                           registered board-updater command
//   count, empty, full              occupancy
//   undo_busy, undo_err             undo in progress / undo on empty history
// -----------------------------------------------------------------------------
module move_history_sequencer
    import chess_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [5:0]             push_from,
    input  logic [5:0]             push_to,
    input  logic [5:0]             push_moving,
    input  logic [5:0]             push_captured,
    input  logic [1:0]             push_castling,
    input  logic [4:0]             push_enpassant,
    input  logic                   push_color,
    input  logic                   undo_req,
    output logic                   upd_enable,
    output logic [63:0]            upd_initialPosition,
    output logic [63:0]            upd_movedPosition,
    output logic [5:0]             upd_movingPiece,
    output logic [5:0]             upd_capturedPiece,
    output logic [1:0]             upd_castling,
    output logic [4:0]             upd_enpassant,
    output logic                   upd_color_type,
    output logic                   upd_undo,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   undo_busy,
    output logic                   undo_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    seq_state_t    r_state;
    logic [AW-1:0] r_top;
    logic [CW-1:0] r_count;
    logic          r_upd_enable;
    logic [63:0]   r_upd_init;
    logic [63:0]   r_upd_moved;
    logic [5:0]    r_upd_moving;
    logic [5:0]    r_upd_captured;
    logic [1:0]    r_upd_castling;
    logic [4:0]    r_upd_enpassant;
    logic          r_upd_color;
    logic          r_upd_undo;
    logic          r_undo_busy;
    logic          r_undo_err;

    move_rec_t     w_wr_rec;
    move_rec_t     w_rd_rec;
    logic          w_push;
    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_rd_addr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef MOVE_HIST_OVERWRITE_EN
    assign push_ready = (r_state == IDLE) && !undo_req;
`else
    assign push_ready = (r_state == IDLE) && !undo_req && !w_full;
`endif

    assign w_push    = push_valid && push_ready;
    assign w_wr_rec  = {push_color, push_enpassant, push_castling,
                        push_captured, push_moving, push_to, push_from};
    // RAM read port always tracks the newest record; the value latched on the
    // edge that enters POP is consumed on the edge that leaves it.
    assign w_rd_addr = r_top - AW'(1);

    move_lifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_top),
        .i_wr_data (w_wr_rec),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_rec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_top           <= '0;
            r_count         <= '0;
            r_upd_enable    <= 1'b0;
            r_upd_init      <= '0;
            r_upd_moved     <= '0;
            r_upd_moving    <= '0;
            r_upd_captured  <= '0;
            r_upd_castling  <= '0;
            r_upd_enpassant <= '0;
            r_upd_color     <= 1'b0;
            r_upd_undo      <= 1'b0;
            r_undo_busy     <= 1'b0;
            r_undo_err      <= 1'b0;
        end else begin
            r_upd_enable <= 1'b0;
            r_undo_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    // undo outranks a simultaneous push
                    if (undo_req) begin
                        if (w_empty) begin
                            r_undo_err <= 1'b1;
                        end else begin
                            r_undo_busy <= 1'b1;
                            r_state     <= POP;
                        end
                    end else if (w_push) begin
                        r_top <= r_top + AW'(1);
                        // a push into a full history (overwrite build) replaces the oldest
                        if (!w_full) begin
                            r_count <= r_count + CW'(1);
                        end
                        r_upd_enable    <= 1'b1;
                        r_upd_undo      <= 1'b0;
                        r_upd_init      <= sq_mask(push_from);
                        r_upd_moved     <= sq_mask(push_to);
                        r_upd_moving    <= push_moving;
                        r_upd_captured  <= push_captured;
                        r_upd_castling  <= push_castling;
                        r_upd_enpassant <= push_enpassant;
                        r_upd_color     <= push_color;
                        r_state         <= APPLY;
                    end
                end
                APPLY: begin
                    r_state <= IDLE;
                end
                POP: begin
                    r_upd_enable    <= 1'b1;
                    r_upd_undo      <= 1'b1;
                    r_upd_init      <= sq_mask(w_rd_rec.from_sq);
                    r_upd_moved     <= sq_mask(w_rd_rec.to_sq);
                    r_upd_moving    <= w_rd_rec.moving;
                    r_upd_captured  <= w_rd_rec.captured;
                    r_upd_castling  <= w_rd_rec.castling;
                    r_upd_enpassant <= w_rd_rec.enpassant;
                    r_upd_color     <= w_rd_rec.color;
                    r_state         <= RETRACT;
                end
                RETRACT: begin
                    r_top       <= r_top - AW'(1);
                    r_count     <= r_count - CW'(1);
                    r_undo_busy <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign upd_enable          = r_upd_enable;
    assign upd_initialPosition = r_upd_init;
    assign upd_movedPosition   = r_upd_moved;
    assign upd_movingPiece     = r_upd_moving;
    assign upd_capturedPiece   = r_upd_captured;
    assign upd_castling        = r_upd_castling;
    assign upd_enpassant       = r_upd_enpassant;
    assign upd_color_type      = r_upd_color;
    assign upd_undo            = r_upd_undo;
    assign count               = r_count;
    assign empty               = w_empty;
    assign full                = w_full;
    assign undo_busy           = r_undo_busy;
    assign undo_err            = r_undo_err;

endmodule
